// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit-side arbitration logic.
// Latency: none (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Arbiter sequencing: wait in IDLE for a winner, then for busy to rise, then to fall.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Purpose: combinational rotating-priority picker; first set bit of (req & mask) at or after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   req_i      request vector
//   ptr_i      index with highest priority this cycle
//   mask_i     candidates allowed to win
//   win_oh_o   one-hot winner (all zero when nothing requests)
//   win_idx_o  binary winner index (0 when nothing requests)
//   any_o      at least one masked request present
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  win_oh_o,
    output logic [IW-1:0] win_idx_o,
    output logic          any_o
);

    localparam int SW = IW + 1;

    logic [N-1:0] req_m;
    logic [SW-1:0] pos;

    assign req_m = req_i & mask_i;

    // Walk the N positions starting at ptr_i, wrapping by subtraction so that
    // non-power-of-two N never produces an out-of-range index.
    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + SW'(k);
            if (pos >= SW'(N)) begin
                pos = pos - SW'(N);
            end
            if (!any_o && req_m[pos[IW-1:0]]) begin
                any_o     = 1'b1;
                win_idx_o = pos[IW-1:0];
            end
        end
        if (any_o) begin
            win_oh_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one uart_tx among NUM_REQ byte streams, with packet locking.
// Latency: uart_tx_en/uart_tx_data appear the cycle after the req_valid & req_ready handshake.
// Backpressure: req_ready is low unless idle with uart_tx_busy low; only the winner sees ready.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   req_valid/last/data per-requester byte stream (requester i uses req_data[8i+7:8i])
//   req_ready           combinational one-hot accept
//   uart_tx_en/data     one-cycle start pulse and registered byte to the transmitter
//   uart_tx_busy        transmitter busy
//   grant_id            requester owning the transmitter or the packet lock
//   grant_active        transfer in flight or packet lock held
//   err_timeout         one-cycle pulse when busy never rose after a start
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 8,
    parameter int IDW          = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           uart_tx_en,
    output logic [UART_DATA_W-1:0]         uart_tx_data,
    input  logic                           uart_tx_busy,
    output logic [IDW-1:0]                 grant_id,
    output logic                           grant_active,
    output logic                           err_timeout
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t             state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                   lock_q, lock_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tx_en_q, tx_en_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IDW-1:0]         gid_q, gid_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     cand_mask;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDW-1:0]         pick_idx;
    logic                   pick_any;
    logic [UART_DATA_W-1:0] data_arr [NUM_REQ];

    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        ptr_inc = (p == IDW'(NUM_REQ - 1)) ? '0 : p + IDW'(1);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = req_data[g*UART_DATA_W +: UART_DATA_W];
    end

    // While a packet is locked only its owner may win, whatever the pointer says.
    assign cand_mask = lock_q ? (NUM_REQ'(1) << gid_q) : '1;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .mask_i    (cand_mask),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        gid_d     = gid_q;
        err_d     = 1'b0;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                // The picker only selects valid requesters, so ready implies a handshake.
                if (!uart_tx_busy && pick_any) begin
                    req_ready = pick_oh;
                    tx_data_d = data_arr[pick_idx];
                    tx_en_d   = 1'b1;
                    gid_d     = pick_idx;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_HI;
                    if (req_last[pick_idx]) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = ptr_inc(pick_idx);
                    end else begin
                        lock_d   = 1'b1;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (uart_tx_busy) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Byte is dropped; release the packet so others are not starved.
                    err_d    = 1'b1;
                    lock_d   = 1'b0;
                    rr_ptr_d = ptr_inc(gid_q);
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!uart_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            gid_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            gid_q     <= gid_d;
            err_q     <= err_d;
        end
    end

    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign grant_id     = gid_q;
    assign err_timeout  = err_q;
    assign grant_active = (state_q != ST_IDLE) | lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: randomized scoreboard bench for uart_tx_arbiter against a transaction-level model.
// Latency: model expects the start pulse one cycle after each accepted byte.
// Backpressure: a behavioural transmitter drives busy with random delay/length, drops and stalls.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int BT = 8;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           uart_tx_en;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_busy;
    logic [1:0]     grant_id;
    logic           grant_active;
    logic           err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .err_timeout  (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pending bytes per requester: {last, data}.
    bit [8:0] rq [N][$];

    typedef struct {
        bit [1:0] id;
        bit [7:0] data;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    // Transaction-level model of the arbiter.
    bit       m_free = 1'b1;
    bit       m_hi   = 1'b0;
    int       m_cnt  = 0;
    int       m_ptr  = 0;
    bit       m_lock = 1'b0;
    int       m_gid  = 0;
    bit       en_exp = 1'b0;
    bit       err_exp = 1'b0;
    bit [N-1:0] acc_vec = '0;

    // Environment knobs / transmitter model state.
    int dly = 0, len = 0, quiet = 0;
    int drop_pct = 0, valid_pct = 100;
    bit hold_busy = 1'b0, spur = 1'b0;

    always @(negedge clk) begin
        bit [N-1:0] exp_rdy;
        int win;
        bit en_nxt, err_nxt;
        exp_t e;
        if (!resetn) begin
            m_free = 1'b1; m_hi = 1'b0; m_cnt = 0; m_ptr = 0; m_lock = 1'b0; m_gid = 0;
            en_exp = 1'b0; err_exp = 1'b0; acc_vec = '0;
            sbq.delete();
        end else begin
            check("grant_active", grant_active, 32'(!m_free || m_lock));
            check("grant_id", grant_id, m_gid);
            check("uart_tx_en", uart_tx_en, en_exp);
            check("err_timeout", err_timeout, err_exp);
            exp_rdy = '0; en_nxt = 1'b0; err_nxt = 1'b0; acc_vec = '0;
            if (m_free) begin
                win = -1;
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % N] && (!m_lock || ((m_ptr + k) % N) == m_gid))
                        win = (m_ptr + k) % N;
                end
                if (win >= 0 && !uart_tx_busy) begin
                    exp_rdy[win] = 1'b1;
                    acc_vec[win] = 1'b1;
                    e.id   = win[1:0];
                    e.data = req_data[win*8 +: 8];
                    sbq.push_back(e);
                    m_gid = win;
                    if (req_last[win]) begin
                        m_lock = 1'b0;
                        m_ptr  = (win + 1) % N;
                    end else begin
                        m_lock = 1'b1;
                    end
                    m_free = 1'b0; m_hi = 1'b1; m_cnt = 0; en_nxt = 1'b1;
                end
            end else if (m_hi) begin
                if (uart_tx_busy) begin
                    m_hi = 1'b0;
                end else begin
                    m_cnt++;
                    if (m_cnt == BT) begin
                        err_nxt = 1'b1; m_lock = 1'b0; m_ptr = (m_gid + 1) % N;
                        m_free = 1'b1; m_hi = 1'b0;
                    end
                end
            end else if (!uart_tx_busy) begin
                m_free = 1'b1;
            end
            check("req_ready", req_ready, exp_rdy);
            en_exp  = en_nxt;
            err_exp = err_nxt;
        end
    end

    // Monitor: every start pulse must match the oldest predicted byte.
    always @(negedge clk) begin
        if (resetn && uart_tx_en) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_unexpected actual data=%0h required none at %0t", uart_tx_data, $time);
            end else begin
                mon_e = sbq.pop_front();
                check("tx_data", uart_tx_data, mon_e.data);
                check("tx_id", grant_id, mon_e.id);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++)
            if (acc_vec[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        quiet++;
        if (uart_tx_en) begin
            quiet = 0;
            if ($urandom_range(99) >= drop_pct) begin
                dly = $urandom_range(0, 2);
                len = $urandom_range(1, 4);
            end
        end
        if (hold_busy) uart_tx_busy = 1'b1;
        else if (dly > 0) begin dly--; uart_tx_busy = 1'b0; end
        else if (len > 0) begin len--; uart_tx_busy = 1'b1; end
        else if (spur && quiet >= 12 && $urandom_range(7) == 0) begin
            len = $urandom_range(0, 2); uart_tx_busy = 1'b1;
        end
        else uart_tx_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                req_valid[i] = 1'b1;
                req_last[i]  = rq[i][0][8];
                req_data[i*8 +: 8] = rq[i][0][7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'($urandom_range(1));
                req_data[i*8 +: 8] = 8'($urandom_range(255));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(all_empty() && m_free && sbq.size() == 0 && dly == 0 && len == 0) && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(n < budget), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_en"}, uart_tx_en, 0);
        check({tag, "_tx_data"}, uart_tx_data, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_grant_active"}, grant_active, 0);
        check({tag, "_err"}, err_timeout, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    initial begin
        int n;
        resetn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; uart_tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;

        // Single byte from requester 2.
        rq[2].push_back({1'b1, 8'h5A});
        drain("drain_single", 100);

        // All requesters, single-byte packets, requester 0 twice.
        for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
        rq[0].push_back({1'b1, 8'h20});
        drain("drain_rr", 200);

        // Three-byte locked packet from requester 0 with requester 1 competing.
        rq[0].push_back({1'b0, 8'h11});
        rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        rq[1].push_back({1'b1, 8'h44});
        drain("drain_lock", 200);

        // Transmitter never goes busy: locked packet times out, next requester proceeds.
        drop_pct = 100;
        rq[2].push_back({1'b0, 8'h55});
        rq[3].push_back({1'b1, 8'h66});
        drain("drain_timeout", 200);
        drop_pct = 0;

        // Busy held high while idle blocks acceptance.
        hold_busy = 1'b1;
        repeat (2) step();
        rq[3].push_back({1'b1, 8'h3C});
        repeat (6) step();
        hold_busy = 1'b0;
        drain("drain_hold", 100);

        // Randomized traffic with drops, stalls and valid gaps.
        spur = 1'b1; drop_pct = 10; valid_pct = 70;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() < 4 && $urandom_range(15) == 0) begin
                    int nb;
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++)
                        rq[i].push_back({(b == nb - 1), 8'($urandom_range(255))});
                end
            end
            step();
        end
        spur = 1'b0; drop_pct = 0; valid_pct = 100;
        drain("drain_random", 3000);

        // Reset asserted while waiting for busy to fall.
        rq[1].push_back({1'b1, 8'hA5});
        rq[2].push_back({1'b1, 8'hC3});
        n = 0;
        while (!(!m_free && !m_hi) && n < 60) begin
            step();
            n++;
        end
        check("reach_wait_lo", 32'(n < 60), 1);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("midreset");
        for (int i = 0; i < N; i++) rq[i].delete();
        dly = 0; len = 0; uart_tx_busy = 1'b0;
        repeat (3) step();
        for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'hD0 + i)});
        step();
        resetn = 1'b1;
        drain("drain_after_reset", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
